mem_port_arbiter: RTL and testbench

- Shares the single external memory port between two requesters: instruction fetch (read-only) and the data cache refill/write-back path (read/write).
- Issues one transaction at a time and gives data priority, with a starvation guard so instruction fetch is still served.
- Holds the transaction stable until the memory acknowledges, then returns read data and pulses an acknowledge to the owning requester.
- Sits between the core's fetch/cache miss logic and the memory model.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_starve_counter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 15;
  localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while instruction fetch is waiting.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data path; data wins
// ties unless instruction fetch has been passed over STARVE_LIMIT times.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy,
  output logic              owner_d
);

  localparam int LIMIT_C = (STARVE_LIMIT < STARVE_LIMIT_MIN) ? STARVE_LIMIT_MIN :
                           (STARVE_LIMIT > STARVE_LIMIT_MAX) ? STARVE_LIMIT_MAX :
                           STARVE_LIMIT;

  arb_state_e        state_q;
  logic              m_req_q, m_we_q, i_ack_q, d_ack_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, i_rdata_q, d_rdata_q;

  logic i_eff, d_eff, at_limit, win_valid, win_owner;
  logic starve_inc, starve_clr;

  // A requester whose ack is high this cycle is still dropping its req; ignore it.
  assign i_eff      = i_req & ~i_ack_q;
  assign d_eff      = d_req & ~d_ack_q;
  assign win_valid  = (state_q == IDLE) & (i_eff | d_eff);
  assign win_owner  = (d_eff & ~(i_eff & at_limit)) ? OWNER_D : OWNER_I;
  assign starve_inc = win_valid & (win_owner == OWNER_D) & i_req;
  assign starve_clr = (win_valid & (win_owner == OWNER_I)) |
                      ((state_q != IDLE) & m_ready & ~i_req);

  arb_starve_counter #(
    .LIMIT (LIMIT_C),
    .CNT_W (STARVE_CNT_W)
  ) u_starve (
    .clk        (CLK),
    .rst        (Reset),
    .inc_i      (starve_inc),
    .clr_i      (starve_clr),
    .at_limit_o (at_limit)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            m_req_q <= 1'b1;
            if (win_owner == OWNER_D) begin
              state_q   <= GRANT_D;
              m_we_q    <= d_we;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
            end else begin
              state_q   <= GRANT_I;
              m_we_q    <= 1'b0;
              m_addr_q  <= i_addr;
              m_wdata_q <= '0;
            end
          end
        end
        GRANT_I: begin
          if (m_ready) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            i_ack_q   <= 1'b1;
            i_rdata_q <= m_rdata;
          end
        end
        GRANT_D: begin
          if (m_ready) begin
            state_q <= IDLE;
            m_req_q <= 1'b0;
            d_ack_q <= 1'b1;
            if (!m_we_q) begin
              d_rdata_q <= m_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);
  assign owner_d = (state_q == GRANT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  // clock / reset
  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  logic          i_req, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          i_ack, d_ack, m_req, m_we, busy, owner_d;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .busy    (busy),
    .owner_d (owner_d)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int i_rate, d_rate, ready_rate, abort_rate;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: owner 0 = none, 1 = instruction, 2 = data
  int            mo;
  int            mcnt;
  logic          e_m_req, e_m_we, e_i_ack, e_d_ack;
  logic [AW-1:0] e_m_addr;
  logic [DW-1:0] e_m_wdata, e_i_rdata, e_d_rdata;

  task automatic model_step();
    bit ie, de, pick_d;
    if (Reset) begin
      mo = 0; mcnt = 0;
      e_m_req = 0; e_m_we = 0; e_m_addr = '0; e_m_wdata = '0;
      e_i_ack = 0; e_d_ack = 0; e_i_rdata = '0; e_d_rdata = '0;
      return;
    end
    ie = i_req && !e_i_ack;
    de = d_req && !e_d_ack;
    e_i_ack = 0;
    e_d_ack = 0;
    if (mo == 0) begin
      pick_d = de && !(ie && mcnt == LIMIT);
      if (pick_d) begin
        mo = 2; e_m_req = 1; e_m_we = d_we; e_m_addr = d_addr; e_m_wdata = d_wdata;
        if (i_req) mcnt = (mcnt < LIMIT) ? mcnt + 1 : LIMIT;
      end else if (ie) begin
        mo = 1; e_m_req = 1; e_m_we = 0; e_m_addr = i_addr; mcnt = 0;
      end
    end else if (m_ready) begin
      if (mo == 1) begin
        e_i_ack = 1; e_i_rdata = m_rdata;
      end else begin
        e_d_ack = 1;
        if (!e_m_we) e_d_rdata = m_rdata;
      end
      mo = 0; e_m_req = 0;
      if (!i_req) mcnt = 0;
    end
  endtask

  task automatic compare_all();
    check("m_req",   m_req,   e_m_req);
    check("busy",    busy,    mo != 0);
    check("owner_d", owner_d, mo == 2);
    check("i_ack",   i_ack,   e_i_ack);
    check("d_ack",   d_ack,   e_d_ack);
    check("i_rdata", i_rdata, e_i_rdata);
    check("d_rdata", d_rdata, e_d_rdata);
    if (e_m_req) begin
      check("m_we",   m_we,   e_m_we);
      check("m_addr", m_addr, e_m_addr);
      if (e_m_we) check("m_wdata", m_wdata, e_m_wdata);
    end
  endtask

  // one clock: model and DUT advance together, outputs compared just after the edge
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
    @(negedge CLK);
  endtask

  // driver tasks
  task automatic new_d();
    d_req   = 1'b1;
    d_we    = $urandom_range(1);
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_wdata = $urandom;
  endtask

  task automatic drive_random();
    if (i_req) begin
      if (i_ack) begin
        if ($urandom_range(99) < i_rate) i_addr = $urandom & 32'hFFFF_FFFC;
        else i_req = 1'b0;
      end
    end else if ($urandom_range(99) < i_rate) begin
      i_req  = 1'b1;
      i_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req) begin
      if (d_ack) begin
        if ($urandom_range(99) < d_rate) new_d();
        else d_req = 1'b0;
      end else if (owner_d && $urandom_range(99) < abort_rate) begin
        d_req = 1'b0;
      end
    end else if ($urandom_range(99) < d_rate) begin
      new_d();
    end
    m_ready = ($urandom_range(99) < ready_rate);
    m_rdata = $urandom;
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive_random();
      tick();
    end
  endtask

  task automatic drain();
    int guard;
    i_rate = 0; d_rate = 0; abort_rate = 0; ready_rate = 60;
    guard = 0;
    while ((i_req || d_req || busy) && guard < 200) begin
      drive_random();
      tick();
      guard++;
    end
    check("drain_timeout", guard < 200, 1'b1);
    m_ready = 1'b0;
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    m_ready = 0; m_rdata = '0;
    @(negedge CLK);
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // instruction read alone, memory answers after three cycles
    i_req = 1'b1; i_addr = 32'h100;
    repeat (3) tick();
    m_ready = 1'b1; m_rdata = 32'hE3A00001;
    tick();
    check("t1_i_ack", i_ack, 1'b1);
    check("t1_i_rdata", i_rdata, 32'hE3A00001);
    check("t1_no_d_ack", d_ack, 1'b0);
    i_req = 1'b0; m_ready = 1'b0;
    tick();

    // simultaneous requests: data write first, then instruction
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF;
    m_ready = 1'b1;
    tick();
    check("t2_first_owner_d", owner_d, 1'b1);
    for (int k = 0; k < 12 && (i_req || d_req); k++) begin
      if (d_ack) d_req = 1'b0;
      if (i_ack) i_req = 1'b0;
      if (i_req || d_req) tick();
    end
    check("t2_done", i_req || d_req, 1'b0);
    m_ready = 1'b0;
    tick();

    // zero-wait memory, three back-to-back reads
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'(k * 4); m_rdata = $urandom;
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!d_ack && lat < 10);
      check("t4_latency", lat, 2);
      d_req = 1'b0;
      tick();
    end
    m_ready = 1'b0;
    tick();

    // reset while data owns the port
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    tick();
    tick();
    check("t5_pre_owner_d", owner_d, 1'b1);
    Reset = 1'b1;
    #1;
    check("t5_rst_m_req", m_req, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_owner_d", owner_d, 1'b0);
    @(negedge CLK);
    tick();
    Reset = 1'b0;
    tick();
    m_ready = 1'b1;
    tick();
    check("t5_after_d_ack", d_ack, 1'b1);
    d_req = 1'b0; m_ready = 1'b0;
    tick();

    // data requester aborts mid-transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick();
    tick();
    d_req = 1'b0;
    tick();
    tick();
    check("t6_m_req_held", m_req, 1'b1);
    m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
    tick();
    check("t6_d_ack", d_ack, 1'b1);
    check("t6_d_rdata", d_rdata, 32'hCAFEF00D);
    m_ready = 1'b0;
    tick();
    check("t6_d_ack_once", d_ack, 1'b0);

    // both requesters continuously busy
    i_rate = 100; d_rate = 100; ready_rate = 60; abort_rate = 0;
    run_random(60);
    drain();

    // general random traffic
    i_rate = 30; d_rate = 40; ready_rate = 50; abort_rate = 5;
    run_random(1500);
    drain();
    i_rate = 50; d_rate = 50; ready_rate = 100; abort_rate = 0;
    run_random(500);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
